fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and load-use hazard controller for the EXE stage of the pipelined MIPS core. It owns a shift-register tracker of in-flight destination writes, one entry per stage from EXE to the last forwarding stage. Each cycle it compares the decode-stage sources against the tracker. From that comparison it produces registered per-source forward selects for EXE and a combinational load-use stall. It supports any number of source operands, forwarding depth and load latency.

---
 rtl/fwd_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the EXE stage of the
// pipelined MIPS core. A shift-register tracker holds one entry per stage
// from EXE to the last forwarding stage. Each cycle the ID sources are
// compared against the tracker to produce registered forward selects for
// EXE and a combinational load-use stall.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_id_valid     ID instruction is valid
//   i_id_src_addr  source register addresses, src k at [k*REG_AW +: REG_AW]
//   i_id_src_used  src k is actually read by the ID instruction
//   i_id_dst_addr  destination register of the ID instruction
//   i_id_reg_write ID instruction writes i_id_dst_addr
//   i_id_mem_read  ID instruction is a load
//   i_flush        kill the ID instruction (branch/jump redirect)
//   o_stall_out    combinational: hold PC and IF/ID, bubble into EXE
//   o_exe_valid    EXE stage holds a valid instruction
//   o_fwd_sel      per-source select for EXE: 0=regfile, k=stage k result
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter  int unsigned REG_AW    = 5,
    parameter  int unsigned NUM_SRC   = 2,
    parameter  int unsigned FWD_DEPTH = 2,
    parameter  int unsigned LOAD_LAT  = 1,
    localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   i_id_src_addr,
    input  logic [NUM_SRC-1:0]          i_id_src_used,
    input  logic [REG_AW-1:0]           i_id_dst_addr,
    input  logic                        i_id_reg_write,
    input  logic                        i_id_mem_read,
    input  logic                        i_flush,
    output logic                        o_stall_out,
    output logic                        o_exe_valid,
    output logic [NUM_SRC*SEL_W-1:0]    o_fwd_sel
);

    // Tracker: entry j describes the instruction entering stage j+1 next edge.
    logic [FWD_DEPTH-1:0]       r_vld;
    logic [FWD_DEPTH-1:0]       r_wr;
    logic [FWD_DEPTH-1:0]       r_ld;
    logic [REG_AW-1:0]          r_dst [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0]   r_fwd_sel;
    logic                       r_exe_valid;

    logic [NUM_SRC*SEL_W-1:0]   w_next_sel;
    logic [NUM_SRC-1:0]         w_src_stall;
    logic                       w_stall;
    logic                       w_adv;

    // Source-vs-tracker compare; scanning oldest to youngest lets the
    // youngest match overwrite, giving it priority.
    always_comb begin
        w_next_sel  = '0;
        w_src_stall = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            for (int j = int'(FWD_DEPTH) - 1; j >= 0; j--) begin
                if (r_vld[j] && r_wr[j] && (r_dst[j] != '0) && i_id_src_used[k] &&
                    (r_dst[j] == i_id_src_addr[k*REG_AW +: REG_AW])) begin
                    w_next_sel[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    // Load data not yet available before stage 1+LOAD_LAT.
                    w_src_stall[k] = r_ld[j] && (j < int'(LOAD_LAT));
                end
            end
        end
    end

    // Flush and invalid ID both suppress the stall; either inserts a bubble.
    always_comb begin
        w_stall = i_id_valid && !i_flush && (|w_src_stall);
        w_adv   = i_id_valid && !i_flush && !w_stall;
    end

    // Tracker shift and registered EXE outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld       <= '0;
            r_wr        <= '0;
            r_ld        <= '0;
            for (int j = 0; j < int'(FWD_DEPTH); j++) begin
                r_dst[j] <= '0;
            end
            r_fwd_sel   <= '0;
            r_exe_valid <= 1'b0;
        end else begin
            for (int j = 1; j < int'(FWD_DEPTH); j++) begin
                r_vld[j] <= r_vld[j-1];
                r_wr[j]  <= r_wr[j-1];
                r_ld[j]  <= r_ld[j-1];
                r_dst[j] <= r_dst[j-1];
            end
            r_vld[0]    <= w_adv;
            r_exe_valid <= w_adv;
            if (w_adv) begin
                r_wr[0]   <= i_id_reg_write;
                r_ld[0]   <= i_id_mem_read;
                r_dst[0]  <= i_id_dst_addr;
                r_fwd_sel <= w_next_sel;
            end else begin
                r_fwd_sel <= '0;
            end
        end
    end

    assign o_stall_out = w_stall;
    assign o_exe_valid = r_exe_valid;
    assign o_fwd_sel   = r_fwd_sel;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Self-checking bench: directed hazard scenarios followed by randomized
// traffic, checked against a reference model that keeps a list of issued
// instructions stamped with the edge at which they entered EXE.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    localparam int unsigned REG_AW    = 5;
    localparam int unsigned NUM_SRC   = 2;
    localparam int unsigned FWD_DEPTH = 2;
    localparam int unsigned LOAD_LAT  = 1;
    localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       id_valid;
    logic [NUM_SRC*REG_AW-1:0]  id_src_addr;
    logic [NUM_SRC-1:0]         id_src_used;
    logic [REG_AW-1:0]          id_dst_addr;
    logic                       id_reg_write;
    logic                       id_mem_read;
    logic                       flush;
    logic                       stall_out;
    logic                       exe_valid;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;

    fwd_hazard_ctrl #(
        .REG_AW    (REG_AW),
        .NUM_SRC   (NUM_SRC),
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_LAT  (LOAD_LAT)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (id_valid),
        .i_id_src_addr  (id_src_addr),
        .i_id_src_used  (id_src_used),
        .i_id_dst_addr  (id_dst_addr),
        .i_id_reg_write (id_reg_write),
        .i_id_mem_read  (id_mem_read),
        .i_flush        (flush),
        .o_stall_out    (stall_out),
        .o_exe_valid    (exe_valid),
        .o_fwd_sel      (fwd_sel)
    );

    always #5 clk = ~clk;

    // Issued instruction, stamped with the edge count at which it entered EXE.
    typedef struct {
        int               cyc;
        logic [REG_AW-1:0] dst;
        logic             wr;
        logic             ld;
    } rec_t;

    rec_t hist[$];
    int   now;
    int   n_vec;
    int   n_err;
    logic obs_stall;
    logic last_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Producer at distance d (1 = currently in EXE) forwards with select d;
    // a load at distance d is not yet usable while d-1 < LOAD_LAT.
    function automatic void model(input logic valid, input logic fl,
                                  input logic [NUM_SRC*REG_AW-1:0] src,
                                  input logic [NUM_SRC-1:0] used,
                                  output logic stall,
                                  output logic [NUM_SRC*SEL_W-1:0] sel);
        stall = 1'b0;
        sel   = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            int   best_d;
            logic best_ld;
            best_d  = 0;
            best_ld = 1'b0;
            foreach (hist[i]) begin
                int d;
                d = now - hist[i].cyc + 1;
                if (d >= 1 && d <= int'(FWD_DEPTH) && hist[i].wr && hist[i].dst != 0 &&
                    used[k] && hist[i].dst == src[k*REG_AW +: REG_AW]) begin
                    if (best_d == 0 || d < best_d) begin
                        best_d  = d;
                        best_ld = hist[i].ld;
                    end
                end
            end
            sel[k*SEL_W +: SEL_W] = SEL_W'(best_d);
            if (best_d != 0 && best_ld && (best_d - 1) < int'(LOAD_LAT)) stall = 1'b1;
        end
        stall = stall && valid && !fl;
    endfunction

    // One ID cycle: drive at negedge, check stall, cross the edge, check EXE.
    task automatic step(input logic v, input logic [REG_AW-1:0] s0, input logic [REG_AW-1:0] s1,
                        input logic [1:0] used, input logic [REG_AW-1:0] dst,
                        input logic wr, input logic ld, input logic fl);
        logic                     e_stall;
        logic [NUM_SRC*SEL_W-1:0] e_sel;
        logic                     issue;
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = used;
        id_dst_addr  = dst;
        id_reg_write = wr;
        id_mem_read  = ld;
        flush        = fl;
        #1;
        model(v, fl, {s1, s0}, used, e_stall, e_sel);
        obs_stall = stall_out;
        chk("stall_out", 32'(stall_out), 32'(e_stall));
        issue = v && !fl && !e_stall;
        @(posedge clk);
        now++;
        if (issue) hist.push_back('{cyc: now, dst: dst, wr: wr, ld: ld});
        while (hist.size() > 0 && (now - hist[0].cyc + 1) > int'(FWD_DEPTH)) void'(hist.pop_front());
        @(negedge clk);
        last_issue = issue;
        chk("exe_valid", 32'(exe_valid), 32'(issue));
        chk("fwd_sel", 32'(fwd_sel), issue ? 32'(e_sel) : 32'd0);
    endtask

    initial begin
        logic       v, fl, wr, ld;
        logic [1:0] used;
        logic [REG_AW-1:0] s0, s1, dst;

        n_vec = 0; n_err = 0; now = 0;
        rst_n = 1'b0;
        id_valid = 1'b0; id_src_addr = '0; id_src_used = '0; id_dst_addr = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_exe_valid", 32'(exe_valid), 32'd0);
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;

        // add r1 ; use r1,r4 -> src0 from stage 1
        step(1, 0, 0, 2'b00, 1, 1, 0, 0);
        step(1, 1, 4, 2'b11, 9, 1, 0, 0);
        chk("dir_fwd_d1", 32'(fwd_sel), 32'h1);
        chk("dir_fwd_d1_stall", 32'(obs_stall), 32'd0);

        // add r2 ; unrelated ; use r2 as src1 -> 2 ; then third distance -> 0
        step(1, 0, 0, 2'b00, 2, 1, 0, 0);
        step(1, 5, 6, 2'b11, 7, 1, 0, 0);
        step(1, 0, 2, 2'b11, 8, 1, 0, 0);
        chk("dir_fwd_d2", 32'(fwd_sel), 32'h8);
        step(1, 2, 0, 2'b11, 10, 1, 0, 0);
        chk("dir_fwd_d3", 32'(fwd_sel), 32'h0);

        // add r1 ; sub r1 ; use r1 -> youngest (1)
        step(1, 0, 0, 2'b00, 1, 1, 0, 0);
        step(1, 0, 0, 2'b00, 1, 1, 0, 0);
        step(1, 1, 0, 2'b11, 11, 1, 0, 0);
        chk("dir_youngest", 32'(fwd_sel), 32'h1);

        // lw r3 ; use r3 as src1 -> one stall, bubble, then select 2
        step(1, 0, 0, 2'b00, 3, 1, 1, 0);
        step(1, 0, 3, 2'b11, 12, 1, 0, 0);
        chk("dir_lu_stall", 32'(obs_stall), 32'd1);
        chk("dir_lu_bubble", 32'(exe_valid), 32'd0);
        step(1, 0, 3, 2'b11, 12, 1, 0, 0);
        chk("dir_lu_nostall", 32'(obs_stall), 32'd0);
        chk("dir_lu_fwd", 32'(fwd_sel), 32'h8);

        // lw r0 ; use r0 -> nothing
        step(1, 0, 0, 2'b00, 0, 1, 1, 0);
        step(1, 0, 0, 2'b11, 13, 1, 0, 0);
        chk("dir_r0_stall", 32'(obs_stall), 32'd0);
        chk("dir_r0_fwd", 32'(fwd_sel), 32'h0);

        // lw r5 ; use r5 with flush -> no stall, bubble
        step(1, 0, 0, 2'b00, 5, 1, 1, 0);
        step(1, 5, 0, 2'b11, 14, 1, 0, 1);
        chk("dir_flush_stall", 32'(obs_stall), 32'd0);
        chk("dir_flush_bubble", 32'(exe_valid), 32'd0);

        // lw r5 ; r5 present but not read -> no stall
        step(1, 0, 0, 2'b00, 5, 1, 1, 0);
        step(1, 5, 5, 2'b00, 15, 1, 0, 0);
        chk("dir_unused_stall", 32'(obs_stall), 32'd0);

        // Reset asserted while a load-use stall is pending
        step(1, 0, 0, 2'b00, 3, 1, 1, 0);
        id_valid = 1'b1; id_src_addr = {5'd3, 5'd0}; id_src_used = 2'b11;
        id_dst_addr = 5'd16; id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
        #1;
        chk("mid_rst_pre_stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        chk("mid_rst_exe_valid", 32'(exe_valid), 32'd0);
        chk("mid_rst_fwd_sel", 32'(fwd_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        step(1, 3, 3, 2'b11, 4, 1, 0, 0);
        chk("post_rst_valid", 32'(exe_valid), 32'd1);

        // Randomized traffic; a stalled instruction is usually re-presented.
        v = 0; fl = 0; wr = 0; ld = 0; used = 0; s0 = 0; s1 = 0; dst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(obs_stall && $urandom_range(0, 9) < 8)) begin
                v    = ($urandom_range(0, 9) != 0);
                s0   = REG_AW'($urandom_range(0, 7));
                s1   = REG_AW'($urandom_range(0, 7));
                used = 2'($urandom_range(0, 3));
                dst  = REG_AW'($urandom_range(0, 7));
                wr   = ($urandom_range(0, 9) < 8);
                ld   = ($urandom_range(0, 9) < 3);
            end
            fl = ($urandom_range(0, 9) == 0);
            step(v, s0, s1, used, dst, wr, ld, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
